// File: rtl/alu_word_seq.sv
// alu_word_seq: runs a 16-bit (or 8-bit) operation through an external 8-bit
// ALU, one byte per cycle, and returns the combined result with N/V/Z/C flags.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_op, req_word        ALU operation, 1 = word / 0 = low byte only
//   req_a, req_b            operands (SBC callers pass req_b already inverted)
//   req_c, req_dec, req_sub carry in, decimal mode, subtract flag
//   alu_a, alu_b, alu_op    byte operands and operation driven to the ALU
//   alu_c_in, alu_dec_*     ALU carry in and decimal add/subtract controls
//   alu_y, alu_c, alu_v     combinational ALU result, carry and overflow
//   rsp_valid / rsp_ready   response handshake
//   rsp_y, rsp_n/v/z/c      result word (high byte 0 for byte ops) and flags
//
// state | meaning
// IDLE  | ready for a request, ALU outputs parked at 0
// STEP1 | first byte on the ALU (low byte, or high byte for word SHR/ASR)
// STEP2 | second byte on the ALU (word operations only)
// DONE  | response presented until rsp_ready
module alu_word_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_word,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_c,
  input  logic        req_dec,
  input  logic        req_sub,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_c_in,
  output logic        alu_dec_add,
  output logic        alu_dec_sub,
  input  logic [7:0]  alu_y,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic        rsp_n,
  output logic        rsp_v,
  output logic        rsp_z,
  output logic        rsp_c
);

  localparam logic [2:0] kALU_ADC = 3'd0;
  localparam logic [2:0] kALU_AND = 3'd1;
  localparam logic [2:0] kALU_OR  = 3'd2;
  localparam logic [2:0] kALU_XOR = 3'd3;
  localparam logic [2:0] kALU_SHL = 3'd4;
  localparam logic [2:0] kALU_SHR = 3'd5;
  localparam logic [2:0] kALU_ASR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic        word_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        c_q;
  logic        dec_q;
  logic        sub_q;
  logic [7:0]  y1_q;
  logic        c1_q;

  logic        is_adc;
  logic        is_shift;
  logic        hi_first;
  logic [7:0]  hi_y;
  logic [7:0]  lo_y;
  logic        fin_c;

  assign is_adc   = (op_q == kALU_ADC);
  assign is_shift = (op_q == kALU_SHL) || (op_q == kALU_SHR) || (op_q == kALU_ASR);
  // Right shifts start at the high byte so the carry ripples downward.
  assign hi_first = word_q && ((op_q == kALU_SHR) || (op_q == kALU_ASR));

  // Second-step view of which captured/live byte is the high one.
  assign hi_y  = hi_first ? y1_q : alu_y;
  assign lo_y  = hi_first ? alu_y : y1_q;
  // Logic ops pass the requester's carry through untouched.
  assign fin_c = (is_adc || is_shift) ? alu_c : c_q;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_op      = 3'd0;
    alu_c_in    = 1'b0;
    alu_dec_add = 1'b0;
    alu_dec_sub = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_nxt = ST_STEP1;
      end
      ST_STEP1: begin
        alu_a       = hi_first ? a_q[15:8] : a_q[7:0];
        alu_b       = hi_first ? b_q[15:8] : b_q[7:0];
        alu_op      = op_q;
        alu_c_in    = c_q;
        alu_dec_add = dec_q & ~sub_q & is_adc;
        alu_dec_sub = dec_q & sub_q & is_adc;
        state_nxt   = word_q ? ST_STEP2 : ST_DONE;
      end
      ST_STEP2: begin
        alu_a       = hi_first ? a_q[7:0] : a_q[15:8];
        alu_b       = hi_first ? b_q[7:0] : b_q[15:8];
        // Low byte of a word ASR is a plain SHR fed by the high byte's carry.
        alu_op      = (op_q == kALU_ASR) ? kALU_SHR : op_q;
        alu_c_in    = c1_q;
        alu_dec_add = dec_q & ~sub_q & is_adc;
        alu_dec_sub = dec_q & sub_q & is_adc;
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= 3'd0;
      word_q <= 1'b0;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      c_q    <= 1'b0;
      dec_q  <= 1'b0;
      sub_q  <= 1'b0;
      y1_q   <= 8'h00;
      c1_q   <= 1'b0;
      rsp_y  <= 16'h0000;
      rsp_n  <= 1'b0;
      rsp_v  <= 1'b0;
      rsp_z  <= 1'b0;
      rsp_c  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && req_valid) begin
        op_q   <= req_op;
        word_q <= req_word;
        a_q    <= req_a;
        b_q    <= req_b;
        c_q    <= req_c;
        dec_q  <= req_dec;
        sub_q  <= req_sub;
      end
      if (state == ST_STEP1) begin
        y1_q <= alu_y;
        c1_q <= alu_c;
        if (!word_q) begin
          rsp_y <= {8'h00, alu_y};
          rsp_n <= alu_y[7];
          rsp_z <= (alu_y == 8'h00);
          rsp_v <= is_adc & alu_v;
          rsp_c <= fin_c;
        end
      end
      if (state == ST_STEP2) begin
        rsp_y <= {hi_y, lo_y};
        rsp_n <= hi_y[7];
        rsp_z <= (hi_y == 8'h00) && (lo_y == 8'h00);
        rsp_v <= is_adc & alu_v;
        rsp_c <= fin_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_word_seq.sv
module tb_alu_word_seq;

  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_ASR = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;
  logic        req_c = 1'b0;
  logic        req_dec = 1'b0;
  logic        req_sub = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_c_in, alu_dec_add, alu_dec_sub;
  logic [7:0]  alu_y;
  logic        alu_c, alu_v;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_y;
  logic        rsp_n, rsp_v, rsp_z, rsp_c;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_on = 1'b0;
  logic [15:0] exp_y;
  logic [3:0]  exp_f;   // {n, v, z, c}

  alu_word_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_dec(req_dec), .req_sub(req_sub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c_in(alu_c_in), .alu_dec_add(alu_dec_add), .alu_dec_sub(alu_dec_sub),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_c(rsp_c)
  );

  always #5 clk = ~clk;

  // 8-bit ALU the sequencer drives.
  logic [8:0] m_s;
  logic [4:0] m_dl, m_dh;
  always_comb begin
    m_s   = 9'h0;
    m_dl  = 5'h0;
    m_dh  = 5'h0;
    alu_y = 8'h00;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      OP_ADC: begin
        if (alu_dec_add) begin
          m_dl = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_c_in};
          if (m_dl > 5'd9) m_dl = m_dl + 5'd6;
          m_dh = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'b0, m_dl[4]};
          if (m_dh > 5'd9) m_dh = m_dh + 5'd6;
          alu_y = {m_dh[3:0], m_dl[3:0]};
          alu_c = m_dh[4];
        end else begin
          m_s   = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
          alu_y = m_s[7:0];
          alu_c = m_s[8];
          alu_v = (alu_a[7] == alu_b[7]) && (m_s[7] != alu_a[7]);
        end
      end
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_XOR: alu_y = alu_a ^ alu_b;
      OP_SHL: begin alu_y = {alu_a[6:0], alu_c_in}; alu_c = alu_a[7]; end
      OP_SHR: begin alu_y = {alu_c_in, alu_a[7:1]}; alu_c = alu_a[0]; end
      OP_ASR: begin alu_y = {alu_a[7], alu_a[7:1]}; alu_c = alu_a[0]; end
      default: alu_y = 8'h00;
    endcase
  end

  // Whole-operand result model: returns {y[15:0], n, v, z, c}.
  function automatic logic [19:0] model(input logic [2:0] op, input logic word,
                                        input logic [15:0] a_in, input logic [15:0] b_in,
                                        input logic c, input logic dec, input logic sub);
    logic [15:0] a, b, y;
    logic [16:0] s;
    logic [4:0]  d;
    logic        cy, co, vo, n;
    int          ndig;
    a  = word ? a_in : {8'h00, a_in[7:0]};
    b  = word ? b_in : {8'h00, b_in[7:0]};
    ndig = word ? 4 : 2;
    y  = 16'h0;
    co = c;
    vo = 1'b0;
    case (op)
      OP_ADC: begin
        if (dec && !sub) begin
          cy = c;
          for (int i = 0; i < ndig; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, cy};
            if (d > 5'd9) begin d = d + 5'd6; cy = 1'b1; end else cy = 1'b0;
            y[4*i +: 4] = d[3:0];
          end
          co = cy;
        end else begin
          s = {1'b0, a} + {1'b0, b} + {16'b0, c};
          if (word) begin
            y = s[15:0]; co = s[16];
            vo = (a[15] == b[15]) && (y[15] != a[15]);
          end else begin
            y = {8'h00, s[7:0]}; co = s[8];
            vo = (a[7] == b[7]) && (y[7] != a[7]);
          end
        end
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: if (word) begin y = {a[14:0], c}; co = a[15]; end
              else begin y = {8'h00, a[6:0], c}; co = a[7]; end
      OP_SHR: begin y = word ? {c, a[15:1]} : {8'h00, c, a[7:1]}; co = a[0]; end
      OP_ASR: begin y = word ? {a[15], a[15:1]} : {8'h00, a[7], a[7:1]}; co = a[0]; end
      default: y = 16'h0;
    endcase
    n = word ? y[15] : y[7];
    return {y, n, vo, (y == 16'h0), co};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle checking: response against the model while valid, parked ALU
  // outputs outside the stepping states.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid && exp_on) begin
        chk("rsp_y", 32'(rsp_y), 32'(exp_y));
        chk("rsp_nvzc", 32'({rsp_n, rsp_v, rsp_z, rsp_c}), 32'(exp_f));
      end
      if (req_ready || rsp_valid) begin
        chk("alu_parked", 32'({alu_a, alu_b, alu_op, alu_c_in, alu_dec_add, alu_dec_sub}), 32'h0);
      end
      if (req_ready) chk("ready_xor_valid", 32'(rsp_valid), 32'h0);
    end
  end

  task automatic do_txn(input logic [2:0] op, input logic word,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic dec, input logic sub,
                        input int hold, input logic keep_valid,
                        output logic [15:0] y, output logic [3:0] f);
    logic [19:0] m;
    logic        hf;
    int          lat;
    hf = word && ((op == OP_SHR) || (op == OP_ASR));
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'h1);
    req_op = op; req_word = word; req_a = a; req_b = b;
    req_c = c; req_dec = dec; req_sub = sub; req_valid = 1'b1;
    m = model(op, word, a, b, c, dec, sub);
    exp_y = m[19:4];
    exp_f = m[3:0];
    exp_on = 1'b1;
    @(negedge clk);
    lat = 1;
    chk("first_byte", 32'(alu_a), 32'(hf ? a[15:8] : a[7:0]));
    chk("first_c_in", 32'(alu_c_in), 32'(c));
    chk("dec_ctl", 32'({alu_dec_add, alu_dec_sub}),
        32'({dec && !sub && (op == OP_ADC), dec && sub && (op == OP_ADC)}));
    // Scramble the request while busy; it must not be taken.
    req_a = ~a; req_b = ~b; req_op = op ^ 3'd1; req_c = ~c; req_word = ~word;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && word) begin
        chk("second_byte", 32'(alu_a), 32'(hf ? a[7:0] : a[15:8]));
        chk("second_op", 32'(alu_op), 32'((op == OP_ASR) ? OP_SHR : op));
      end
    end
    chk("latency", 32'(lat), word ? 32'd3 : 32'd2);
    y = rsp_y;
    f = {rsp_n, rsp_v, rsp_z, rsp_c};
    if (!keep_valid) req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("held_valid", 32'({rsp_valid, req_ready}), 32'b10);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("back_idle", 32'({req_ready, rsp_valid}), 32'b10);
    exp_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [15:0] ry;
  logic [3:0]  rf;

  initial begin
    #1;
    chk("reset_state", 32'({req_ready, rsp_valid, rsp_y, rsp_n, rsp_v, rsp_z, rsp_c}),
        32'({1'b1, 1'b0, 16'h0, 4'h0}));
    chk("reset_alu", 32'({alu_a, alu_b, alu_op, alu_c_in}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Pinned vectors (hand-computed).
    do_txn(OP_ADC, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_adc_word", 32'({ry, rf}), 32'({16'h0100, 4'b0000}));
    do_txn(OP_ADC, 1'b1, 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_adc_dec", 32'({ry, rf[0]}), 32'({16'h1000, 1'b0}));
    do_txn(OP_SHR, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_shr_word", 32'({ry, rf[0]}), 32'({16'hC000, 1'b1}));
    do_txn(OP_ASR, 1'b1, 16'h8002, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_asr_word", 32'({ry, rf[3], rf[0]}), 32'({16'hC001, 1'b1, 1'b0}));
    do_txn(OP_AND, 1'b0, 16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_and_byte", 32'({ry, rf[1], rf[0]}), 32'({16'h0000, 1'b1, 1'b1}));
    do_txn(OP_ADC, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_adc_ovf", 32'({ry, rf}), 32'({16'h8000, 4'b1100}));
    do_txn(OP_ADC, 1'b1, 16'h0005, 16'hFFFC, 1'b1, 1'b0, 1'b1, 0, 1'b0, ry, rf);
    chk("pin_sbc_word", 32'({ry, rf}), 32'({16'h0002, 4'b0001}));
    do_txn(OP_SHL, 1'b1, 16'h8080, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    chk("pin_shl_word", 32'({ry, rf}), 32'({16'h0101, 4'b0001}));

    // Model-only vectors.
    do_txn(OP_ADC, 1'b0, 16'h127F, 16'h3401, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_SHR, 1'b0, 16'hFF81, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_ASR, 1'b0, 16'h0083, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_OR,  1'b0, 16'hAB50, 16'hCD0A, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_XOR, 1'b1, 16'hA55A, 16'hFF00, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_ADC, 1'b0, 16'h0058, 16'h0046, 1'b1, 1'b1, 1'b0, 0, 1'b0, ry, rf);
    do_txn(OP_AND, 1'b1, 16'h0F0F, 16'h00FF, 1'b0, 1'b0, 1'b0, 0, 1'b0, ry, rf);

    // Backpressure with req_valid left high through DONE and the return to IDLE.
    do_txn(OP_ADC, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 5, 1'b1, ry, rf);
    chk("pin_backpressure", 32'(ry), 32'h5556);

    // Reset while in STEP2: abandon without a response.
    @(negedge clk);
    req_op = OP_ADC; req_word = 1'b1; req_a = 16'h1111; req_b = 16'h2222;
    req_c = 1'b0; req_dec = 1'b0; req_sub = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("step2_reached", 32'({req_ready, rsp_valid, alu_a}), 32'({2'b00, 8'h11}));
    reset_n = 1'b0;
    #1;
    chk("async_reset", 32'({req_ready, rsp_valid, alu_a, alu_b, rsp_y}),
        32'({2'b10, 8'h00, 8'h00, 16'h0000}));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'({req_ready, rsp_valid}), 32'b10);
    end

    // Normal operation resumes after reset.
    do_txn(OP_ADC, 1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 1'b0, ry, rf);
    chk("pin_adc_byte", 32'({ry, rf}), 32'({16'h0000, 4'b0011}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
